// File: rtl/hls_flow_pkg.sv
// ---------------------------------------------------------------------------
// hls_flow_pkg
// Shared constants for the HLS loop flow controller and its operand mux.
//   OPERAND_W      : operand width of the loop-index operand selector
//   SEL_W          : select width of the operand selector
//   LOOP_INIT_RST  : reset value of the first-iteration flag
//   DONE_CACHE_RST : reset value of the done cache (FLOW_CTRL_DONE_CACHE_EN)
// ---------------------------------------------------------------------------
package hls_flow_pkg;

   localparam int   OPERAND_W      = 21;
   localparam int   SEL_W          = 2;
   localparam logic LOOP_INIT_RST  = 1'b1;
   localparam logic DONE_CACHE_RST = 1'b0;

endpackage

// File: rtl/mux_32_21_1_1.sv
// ---------------------------------------------------------------------------
// mux_32_21_1_1
// Combinational 3:1 operand selector driven by a 2-bit loop index.
//   din3 = 0 -> din0, 1 -> din1, 2 -> din2, 3 -> din2
// Built as a two-level tree: din3[0] picks din0/din1, din3[1] picks that
// result or din2. Bits pass through unchanged; zero latency.
// Ports:
//   din0, din1, din2 : in  candidate operands
//   din3             : in  select
//   dout             : out selected operand
// Parameters ID and NUM_STAGE are informational only.
// ---------------------------------------------------------------------------
module mux_32_21_1_1
   import hls_flow_pkg::*;
#(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 1,
   parameter int din0_WIDTH = OPERAND_W,
   parameter int din1_WIDTH = OPERAND_W,
   parameter int din2_WIDTH = OPERAND_W,
   parameter int din3_WIDTH = SEL_W,
   parameter int dout_WIDTH = OPERAND_W
) (
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic [din2_WIDTH-1:0] din2,
   input  logic [din3_WIDTH-1:0] din3,
   output logic [dout_WIDTH-1:0] dout
);

   // Instance tag and stage count carry no function.
   localparam int unused_cfg = ID + NUM_STAGE;

   logic [dout_WIDTH-1:0] lvl0_y;

   mux_32_21_1_1_mux2 #(.W(dout_WIDTH)) u_lvl0 (
      .a_i   (din0),
      .b_i   (din1),
      .sel_i (din3[0]),
      .y_o   (lvl0_y)
   );

   mux_32_21_1_1_mux2 #(.W(dout_WIDTH)) u_lvl1 (
      .a_i   (lvl0_y),
      .b_i   (din2),
      .sel_i (din3[1]),
      .y_o   (dout)
   );

endmodule

// File: rtl/mux_32_21_1_1_mux2.sv
// ---------------------------------------------------------------------------
// mux_32_21_1_1_mux2
// 2:1 mux cell used to build the operand selector tree.
// Ports:
//   a_i   : in  [W-1:0] operand chosen when sel_i = 0
//   b_i   : in  [W-1:0] operand chosen when sel_i = 1
//   sel_i : in           select
//   y_o   : out [W-1:0] selected operand
// ---------------------------------------------------------------------------
module mux_32_21_1_1_mux2 #(
   parameter int W = 21
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         sel_i,
   output logic [W-1:0] y_o
);

   assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/flow_control_loop_pipe_sequential_init.sv
// ---------------------------------------------------------------------------
// flow_control_loop_pipe_sequential_init
// Loop-start / loop-exit handshake controller for a single-stage pipelined
// sequential HLS loop. Produces ap_loop_init, high for the first iteration
// of every run so the body can reset its induction variable.
// Optional feature macro: FLOW_CTRL_DONE_CACHE_EN
//   defined   : ap_done is stretched one cycle past exit by a done cache
//   undefined : ap_done = ap_loop_exit_done (combinational)
// Ports:
//   ap_clk             : in  clock
//   ap_rst             : in  asynchronous reset, active-low
//   ap_start           : in  function start from caller
//   ap_ready           : out function ready to caller
//   ap_done            : out function done to caller
//   ap_start_int       : out start forwarded to loop body
//   ap_loop_init       : out first-iteration flag
//   ap_ready_int       : in  body accepted an iteration this cycle
//   ap_loop_exit_ready : in  loop exit reached this cycle
//   ap_loop_exit_done  : in  body signals done
//   ap_continue_int    : out continue to body (always 1)
//   ap_done_int        : in  body done status, reserved
// ---------------------------------------------------------------------------
module flow_control_loop_pipe_sequential_init
   import hls_flow_pkg::*;
(
   input  logic ap_clk,
   input  logic ap_rst,
   input  logic ap_start,
   output logic ap_ready,
   output logic ap_done,
   output logic ap_start_int,
   output logic ap_loop_init,
   input  logic ap_ready_int,
   input  logic ap_loop_exit_ready,
   input  logic ap_loop_exit_done,
   output logic ap_continue_int,
   input  logic ap_done_int
);

   logic unused_done_int;
   assign unused_done_int = ap_done_int;

   // Sequential loop: no downstream stall, so start passes straight through.
   assign ap_start_int    = ap_start;
   assign ap_continue_int = 1'b1;
   assign ap_ready        = ap_loop_exit_ready;

   // First-iteration flag: exit re-arms it and wins over an accepted iteration.
   logic ap_loop_init_q, ap_loop_init_d;

   always_comb begin
      ap_loop_init_d = ap_loop_init_q;
      if (ap_loop_exit_ready)
         ap_loop_init_d = 1'b1;
      else if (ap_ready_int)
         ap_loop_init_d = 1'b0;
   end

   always_ff @(posedge ap_clk or negedge ap_rst) begin
      if (!ap_rst)
         ap_loop_init_q <= LOOP_INIT_RST;
      else
         ap_loop_init_q <= ap_loop_init_d;
   end

   assign ap_loop_init = ap_loop_init_q;

`ifdef FLOW_CTRL_DONE_CACHE_EN
   // Holds done for the cycle after exit; continue is always high so the
   // cache clears one cycle later.
   logic ap_done_cache_q, ap_done_cache_d;

   always_comb begin
      ap_done_cache_d = ap_done_cache_q;
      if (ap_loop_exit_done)
         ap_done_cache_d = 1'b1;
      else if (ap_continue_int)
         ap_done_cache_d = 1'b0;
   end

   always_ff @(posedge ap_clk or negedge ap_rst) begin
      if (!ap_rst)
         ap_done_cache_q <= DONE_CACHE_RST;
      else
         ap_done_cache_q <= ap_done_cache_d;
   end

   assign ap_done = ap_loop_exit_done | ap_done_cache_q;
`else
   assign ap_done = ap_loop_exit_done;
`endif

endmodule

// File: tb/tb_flow_control_loop_pipe_sequential_init.sv
// ---------------------------------------------------------------------------
// Testbench for flow_control_loop_pipe_sequential_init and mux_32_21_1_1.
// ---------------------------------------------------------------------------
module tb_flow_control_loop_pipe_sequential_init;

`ifdef FLOW_CTRL_DONE_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic ap_clk = 1'b0;
   logic ap_rst;
   logic ap_start, ap_ready, ap_done, ap_start_int, ap_loop_init;
   logic ap_ready_int, ap_loop_exit_ready, ap_loop_exit_done;
   logic ap_continue_int, ap_done_int;

   logic [20:0] din0, din1, din2, dout;
   logic [1:0]  din3;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   bit m_first;      // next accepted iteration is the first of a run
   bit m_exd_prev;   // exit_done seen in the previous cycle

   always #5 ap_clk = ~ap_clk;

   flow_control_loop_pipe_sequential_init dut (
      .ap_clk             (ap_clk),
      .ap_rst             (ap_rst),
      .ap_start           (ap_start),
      .ap_ready           (ap_ready),
      .ap_done            (ap_done),
      .ap_start_int       (ap_start_int),
      .ap_loop_init       (ap_loop_init),
      .ap_ready_int       (ap_ready_int),
      .ap_loop_exit_ready (ap_loop_exit_ready),
      .ap_loop_exit_done  (ap_loop_exit_done),
      .ap_continue_int    (ap_continue_int),
      .ap_done_int        (ap_done_int)
   );

   mux_32_21_1_1 u_mux (
      .din0 (din0),
      .din1 (din1),
      .din2 (din2),
      .din3 (din3),
      .dout (dout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [20:0] mux_ref(input logic [20:0] a, b, c, input logic [1:0] s);
      case (s)
         2'd0:    return a;
         2'd1:    return b;
         default: return c;
      endcase
   endfunction

   // One clock cycle: drive inputs after the falling edge, check outputs,
   // then advance the model across the rising edge.
   task automatic cycle(input logic st, input logic rdy, input logic exr, input logic exd);
      @(negedge ap_clk);
      ap_start           = st;
      ap_ready_int       = rdy;
      ap_loop_exit_ready = exr;
      ap_loop_exit_done  = exd;
      ap_done_int        = 1'($urandom_range(0, 1));
      #1;
      chk("loop_init", {31'd0, ap_loop_init}, {31'd0, m_first});
      chk("ready",     {31'd0, ap_ready},     {31'd0, exr});
      chk("done",      {31'd0, ap_done},      {31'd0, exd | (CACHE & m_exd_prev)});
      chk("start_int", {31'd0, ap_start_int}, {31'd0, st});
      chk("continue",  {31'd0, ap_continue_int}, 32'd1);
      @(posedge ap_clk);
      if (exr)      m_first = 1'b1;
      else if (rdy) m_first = 1'b0;
      m_exd_prev = exd;
   endtask

   // Asynchronous reset pulse asserted between clock edges.
   task automatic reset_pulse();
      @(negedge ap_clk);
      ap_start = 1'b0; ap_ready_int = 1'b0;
      ap_loop_exit_ready = 1'b0; ap_loop_exit_done = 1'b0;
      #2;
      ap_rst = 1'b0;
      #1;
      chk("async_rst_init", {31'd0, ap_loop_init}, 32'd1);
      chk("async_rst_done", {31'd0, ap_done},      32'd0);
      @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst     = 1'b1;
      m_first    = 1'b1;
      m_exd_prev = 1'b0;
   endtask

   initial begin
      ap_rst = 1'b0;
      ap_start = 1'b0; ap_ready_int = 1'b0; ap_loop_exit_ready = 1'b0;
      ap_loop_exit_done = 1'b0; ap_done_int = 1'b0;
      din0 = '0; din1 = '0; din2 = '0; din3 = '0;
      m_first = 1'b1; m_exd_prev = 1'b0;

      // Reset held
      repeat (2) @(posedge ap_clk);
      @(negedge ap_clk);
      chk("rst_loop_init", {31'd0, ap_loop_init}, 32'd1);
      chk("rst_done",      {31'd0, ap_done},      32'd0);
      ap_rst = 1'b1;

      // Release with no accepted iteration: flag stays armed
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // Run of 3 iterations, exit on the 4th accepted cycle
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // Exit and accept together while armed: stays armed
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // Back-to-back runs
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // Mid-run reset
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      reset_pulse();
      cycle(1'b1, 1'b1, 1'b0, 1'b0);

      // Randomized control traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0)
            reset_pulse();
         else
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      end

      // Mux directed vectors
      din0 = 21'h00001; din1 = 21'h0FFFFF; din2 = 21'h100000;
      for (int s = 0; s < 4; s++) begin
         din3 = 2'(s);
         #1;
         chk("mux_dir", {11'd0, dout}, {11'd0, mux_ref(21'h00001, 21'h0FFFFF, 21'h100000, 2'(s))});
      end

      // Mux random vectors
      for (int i = 0; i < 64; i++) begin
         din0 = 21'($urandom); din1 = 21'($urandom); din2 = 21'($urandom);
         din3 = 2'($urandom_range(0, 3));
         #1;
         chk("mux_rnd", {11'd0, dout}, {11'd0, mux_ref(din0, din1, din2, din3)});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
